// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI-style serial front end feeding RAM command words and returning read data
//
// Frames arrive MSB first on MOSI, one bit per rising clk edge while SS_n is low:
// one command bit followed by PAY_W payload bits. The payload is handed to the
// RAM unmodified on rx_data with a one-cycle rx_valid strobe. A read-data frame
// additionally waits for the RAM's tx_valid, then shifts tx_data out on MISO.
//
// Ports:
//   clk       in   1        system clock, also the serial bit clock
//   rst_n     in   1        asynchronous active-low reset
//   SS_n      in   1        slave select, active low, frames a transaction
//   MOSI      in   1        serial data in, MSB first
//   MISO      out  1        serial data out, MSB first, 0 when not serialising
//   rx_data   out  PAY_W    command word to RAM din ({op[1:0], byte[7:0]})
//   rx_valid  out  1        one-cycle strobe, rx_data valid
//   tx_data   in   DATA_W   read data from RAM dout
//   tx_valid  in   1        RAM read data valid

module spi_slave_ctrl #(
    parameter int PAY_W  = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [PAY_W-1:0]  rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int CNT_W = $clog2(PAY_W + 1);
    localparam int TXC_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PAY_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAY_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [TXC_W-1:0] TXL_INIT = TXC_W'(DATA_W - 1);
    localparam logic [TXC_W-1:0] TXL_ONE  = TXC_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t              state_q,        state_d;
    logic [CNT_W-1:0]    bit_cnt_q,      bit_cnt_d;
    logic [PAY_W-1:0]    rx_shift_q,     rx_shift_d;
    logic [PAY_W-1:0]    rx_data_q,      rx_data_d;
    logic                rx_valid_q,     rx_valid_d;
    logic                rd_addr_done_q, rd_addr_done_d;
    logic                miso_q,         miso_d;
    logic [DATA_W-1:0]   tx_shift_q,     tx_shift_d;
    logic [TXC_W-1:0]    tx_left_q,      tx_left_d;
    logic                tx_active_q,    tx_active_d;
    logic                tx_done_q,      tx_done_d;

    // Shift register contents including the bit sampled on this edge.
    logic [PAY_W-1:0]    rx_shifted;
    logic                payload_open;

    assign rx_shifted   = {rx_shift_q[PAY_W-2:0], MOSI};
    // Counter saturates at PAY_W; once full, extra bits in the frame are dropped.
    assign payload_open = (bit_cnt_q != CNT_FULL);

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_done_d = rd_addr_done_q;
        miso_d         = miso_q;
        tx_shift_d     = tx_shift_q;
        tx_left_d      = tx_left_q;
        tx_active_d    = tx_active_q;
        tx_done_d      = tx_done_q;

        if (SS_n) begin
            // Deselect aborts whatever is in flight; rd_addr_done survives so a
            // read address already delivered still pairs with the next read-data frame.
            state_d     = IDLE;
            bit_cnt_d   = '0;
            rx_shift_d  = '0;
            miso_d      = 1'b0;
            tx_shift_d  = '0;
            tx_left_d   = '0;
            tx_active_d = 1'b0;
            tx_done_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = CHK_CMD;
                    bit_cnt_d = '0;
                end

                CHK_CMD: begin
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    if (!MOSI) begin
                        state_d = WRITE;
                    end else if (!rd_addr_done_q) begin
                        state_d = READ_ADD;
                    end else begin
                        state_d = READ_DATA;
                    end
                end

                WRITE, READ_ADD, READ_DATA: begin
                    if (payload_open) begin
                        rx_shift_d = rx_shifted;
                        bit_cnt_d  = bit_cnt_q + CNT_ONE;
                        if (bit_cnt_q == CNT_LAST) begin
                            rx_data_d  = rx_shifted;
                            rx_valid_d = 1'b1;
                            if (state_q == READ_ADD) begin
                                rd_addr_done_d = 1'b1;
                            end
                        end
                    end else if (state_q == READ_DATA) begin
                        if (tx_active_q) begin
                            // tx_left counts bits still queued behind the one on MISO.
                            if (tx_left_q != '0) begin
                                miso_d     = tx_shift_q[DATA_W-1];
                                tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                                tx_left_d  = tx_left_q - TXL_ONE;
                            end else begin
                                miso_d         = 1'b0;
                                tx_active_d    = 1'b0;
                                tx_done_d      = 1'b1;
                                rd_addr_done_d = 1'b0;
                            end
                        end else if (!tx_done_q && tx_valid) begin
                            // MSB goes straight to MISO so it appears the cycle after tx_valid.
                            miso_d      = tx_data[DATA_W-1];
                            tx_shift_d  = {tx_data[DATA_W-2:0], 1'b0};
                            tx_left_d   = TXL_INIT;
                            tx_active_d = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_done_q <= 1'b0;
            miso_q         <= 1'b0;
            tx_shift_q     <= '0;
            tx_left_q      <= '0;
            tx_active_q    <= 1'b0;
            tx_done_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_done_q <= rd_addr_done_d;
            miso_q         <= miso_d;
            tx_shift_q     <= tx_shift_d;
            tx_left_q      <= tx_left_d;
            tx_active_q    <= tx_active_d;
            tx_done_q      <= tx_done_d;
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule
